vram_scanout_reader: RTL

// - Scanout fetch stage sitting directly on the read-only port (port B) of the dual-port framebuffer VRAM.
// - Walks one 320x240 RGB565 frame from one of two framebuffers: buffer 0 at word 0, buffer 1 at word 76800.
// - Delivers pixels as a valid/ready stream to the video output / timing stage.
// - Absorbs the VRAM's 1-cycle read latency and downstream backpressure with a small output FIFO.

---
 rtl/vram_scanout_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vram_scanout_reader.sv
// Scanout fetch stage: walks one framebuffer over the VRAM read port and streams pixels out through a small FWFT FIFO.
// Optional underrun counter is compiled in with `define VRAM_SCANOUT_UNDERRUN_EN.
module vram_scanout_reader #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_start,
  input  logic              i_buffer_select,
  output logic              o_vram_enable,
  output logic [ADDR_W-1:0] o_vram_address,
  output logic              o_vram_write_en,
  input  logic [DATA_W-1:0] i_vram_rd_data,
  output logic [DATA_W-1:0] o_pixel_data,
  output logic              o_pixel_valid,
  input  logic              i_pixel_ready,
  output logic              o_pixel_sol,
  output logic              o_pixel_sof,
  output logic              o_frame_done,
  output logic [15:0]       o_underrun_count
);

  // Pixel stream: a pixel transfers on every cycle where o_pixel_valid && i_pixel_ready;
  // head data and tags stay stable while valid && !ready, and valid only falls after a pop,
  // a frame-start flush, or reset.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              r_state, w_state_next;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_inflight, r_inf_sol, r_inf_sof, r_inf_last;
  logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_sol, r_mem_sof, r_mem_last;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic                w_issue, w_push, w_pop, w_empty, w_x_last, w_y_last;
  logic [PTR_W+1:0]    w_occupancy;

  assign w_empty  = (r_count == '0);
  assign w_x_last = (r_x == X_W'(H_ACTIVE - 1));
  assign w_y_last = (r_y == Y_W'(V_ACTIVE - 1));
  // A restart flushes everything, so nothing pops or lands in the FIFO on that cycle.
  assign w_pop    = !w_empty && i_pixel_ready && !i_frame_start;
  assign w_push   = r_inflight && !i_frame_start;
  assign w_occupancy = {1'b0, r_count} + (PTR_W+2)'(r_inflight) - (PTR_W+2)'(w_pop);
  assign w_issue  = (r_state == S_FETCH) && !i_frame_start &&
                    (w_occupancy < (PTR_W+2)'(FIFO_DEPTH));

  always_comb begin
    w_state_next = r_state;
    if (i_frame_start) begin
      w_state_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: if (w_issue && w_x_last && w_y_last) w_state_next = S_DRAIN;
        S_DRAIN: if (w_empty && !r_inflight) w_state_next = S_IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_inf_sol  <= 1'b0;
      r_inf_sof  <= 1'b0;
      r_inf_last <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_sol  <= (r_x == '0);
        r_inf_sof  <= (r_x == '0) && (r_y == '0);
        r_inf_last <= w_x_last && w_y_last;
      end
      if (i_frame_start) begin
        r_x      <= '0;
        r_y      <= '0;
        r_addr   <= i_buffer_select ? BASE1 : '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_issue) begin
          r_addr <= r_addr + 1'b1;
          if (w_x_last) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
    end
  end

  // Storage needs no reset: r_count gates every read of it.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_vram_rd_data;
      r_mem_sol[r_wr_ptr]  <= r_inf_sol;
      r_mem_sof[r_wr_ptr]  <= r_inf_sof;
      r_mem_last[r_wr_ptr] <= r_inf_last;
    end
  end

  assign o_vram_enable   = w_issue;
  assign o_vram_address  = r_addr;
  assign o_vram_write_en = 1'b0;
  assign o_pixel_valid   = !w_empty;
  assign o_pixel_data    = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign o_pixel_sol     = !w_empty && r_mem_sol[r_rd_ptr];
  assign o_pixel_sof     = !w_empty && r_mem_sof[r_rd_ptr];
  assign o_frame_done    = w_pop && r_mem_last[r_rd_ptr];

`ifdef VRAM_SCANOUT_UNDERRUN_EN
  logic [15:0] r_underrun;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_underrun <= '0;
    end else if (i_frame_start) begin
      r_underrun <= '0;
    end else if ((r_state != S_IDLE) && i_pixel_ready && w_empty &&
                 (r_underrun != 16'hFFFF)) begin
      r_underrun <= r_underrun + 16'd1;
    end
  end

  assign o_underrun_count = r_underrun;
`else
  assign o_underrun_count = 16'h0;
`endif

endmodule
